// File: rtl/definitions_pkg.sv
// Shared types and window geometry for the strength-window producer.
package definitions_pkg;

    typedef logic [1:0] strength_t;

    localparam strength_t STR_NONE   = 2'b00;
    localparam strength_t STR_STRONG = 2'b01;
    localparam strength_t STR_WEAK   = 2'b10;

    typedef enum logic [1:0] {FILL, STREAM, FLUSH} win_state_t;

    localparam int unsigned WIN_DIM  = 3;
    localparam int unsigned WIN_BITS = 18;

endpackage

// File: rtl/strength_line_buffer.sv
// One image line of 2-bit classifications; combinational read of the old
// entry at addr, with the new value written at the same address on the edge.
module strength_line_buffer #(
    parameter int unsigned DEPTH = 640,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          wr_en,
    input  logic [1:0]    wr_data,
    output logic [1:0]    rd_data
);

    logic [1:0] mem [DEPTH];

    // Read-before-write: rd_data shows the entry from one line earlier.
    assign rd_data = mem[addr];

    // Storage update; contents need no reset, border masking hides them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/strength_window_gen.sv
// Raster stream of edge classifications in, one zero-padded 3x3 window per
// pixel out, packed as entry (row*3+col) at bits [i*2+:2].
module strength_window_gen
    import definitions_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          strength_in,
    input  logic                strength_in_valid,
    output logic                strength_in_ready,
    output logic [WIN_BITS-1:0] strength_value,
    output logic                strength_valid
);

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

    win_state_t          state_q, state_d;
    logic                ready_q, ready_d;
    logic [CW-1:0]       in_col_q, in_col_d, ctr_col_q, ctr_col_d;
    logic [RW-1:0]       in_row_q, in_row_d, ctr_row_q, ctr_row_d;
    logic [WIN_BITS-1:0] win_q, win_d, masked;
    logic [WIN_BITS-1:0] value_q, value_d;
    logic                valid_q, valid_d;

    logic      accept, shift, emit;
    strength_t new_px, mid_px, top_px;
    strength_t col_px [WIN_DIM];

    assign accept = strength_in_valid && ready_q;
    assign shift  = accept || (state_q == FLUSH);
    assign emit   = (accept && (state_q == STREAM)) || (state_q == FLUSH);
    // Flush feeds zeros; they only ever land in masked bottom-row slots.
    assign new_px = (state_q == FLUSH) ? STR_NONE : strength_in;

    // Chained line buffers: mid_px is one line back, top_px two lines back.
    strength_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb_mid (
        .clk     (clk),
        .addr    (in_col_q),
        .wr_en   (shift),
        .wr_data (new_px),
        .rd_data (mid_px)
    );

    strength_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb_top (
        .clk     (clk),
        .addr    (in_col_q),
        .wr_en   (shift),
        .wr_data (mid_px),
        .rd_data (top_px)
    );

    // Shift the window left one column and insert the new column on the right.
    always_comb begin
        col_px[0] = top_px;
        col_px[1] = mid_px;
        col_px[2] = new_px;
        win_d     = win_q;
        if (shift) begin
            for (int r = 0; r < WIN_DIM; r++) begin
                win_d[(r*3)*2 +: 2]   = win_q[(r*3+1)*2 +: 2];
                win_d[(r*3+1)*2 +: 2] = win_q[(r*3+2)*2 +: 2];
                win_d[(r*3+2)*2 +: 2] = col_px[r];
            end
        end
    end

    // Zero rows/columns outside the image, keyed only on the centre position.
    always_comb begin
        masked = win_d;
        for (int i = 0; i < WIN_DIM; i++) begin
            if (ctr_row_q == '0)      masked[i*2 +: 2]           = STR_NONE;
            if (ctr_row_q == LAST_ROW) masked[(6+i)*2 +: 2]      = STR_NONE;
            if (ctr_col_q == '0)      masked[(i*3)*2 +: 2]       = STR_NONE;
            if (ctr_col_q == LAST_COL) masked[(i*3+2)*2 +: 2]    = STR_NONE;
        end
    end

    // Next-state, counter and output-register logic.
    always_comb begin
        state_d   = state_q;
        in_col_d  = in_col_q;
        in_row_d  = in_row_q;
        ctr_col_d = ctr_col_q;
        ctr_row_d = ctr_row_q;
        value_d   = emit ? masked : value_q;
        valid_d   = emit;

        if (shift) begin
            if (in_col_q == LAST_COL) begin
                in_col_d = '0;
                in_row_d = (in_row_q == LAST_ROW) ? '0 : in_row_q + 1'b1;
            end else begin
                in_col_d = in_col_q + 1'b1;
            end
        end
        if (emit) begin
            if (ctr_col_q == LAST_COL) begin
                ctr_col_d = '0;
                ctr_row_d = (ctr_row_q == LAST_ROW) ? '0 : ctr_row_q + 1'b1;
            end else begin
                ctr_col_d = ctr_col_q + 1'b1;
            end
        end

        unique case (state_q)
            FILL: begin
                if (accept && in_row_q == RW'(1) && in_col_q == '0) state_d = STREAM;
            end
            STREAM: begin
                if (accept && in_row_q == LAST_ROW && in_col_q == LAST_COL) state_d = FLUSH;
            end
            FLUSH: begin
                if (ctr_row_q == LAST_ROW && ctr_col_q == LAST_COL) begin
                    state_d   = FILL;
                    in_col_d  = '0;
                    in_row_d  = '0;
                    ctr_col_d = '0;
                    ctr_row_d = '0;
                end
            end
            default: state_d = FILL;
        endcase

        // Registered so ready stays low throughout reset.
        ready_d = (state_d != FLUSH);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            ready_q   <= 1'b0;
            in_col_q  <= '0;
            in_row_q  <= '0;
            ctr_col_q <= '0;
            ctr_row_q <= '0;
            win_q     <= '0;
            value_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            in_col_q  <= in_col_d;
            in_row_q  <= in_row_d;
            ctr_col_q <= ctr_col_d;
            ctr_row_q <= ctr_row_d;
            win_q     <= win_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
        end
    end

    assign strength_in_ready = ready_q;
    assign strength_value    = value_q;
    assign strength_valid    = valid_q;

endmodule
